// File: rtl/mult_share_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
package mult_share_pkg;
  localparam int OP_W         = 16;
  localparam int PROD_W       = 32;
  localparam int N_REQ_DEF    = 4;
  localparam int MULT_LAT_DEF = 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mult_share_ctrl_if.sv
// Request, multiplier and response bus of mult_share_ctrl; slave = controller side.
interface mult_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  import mult_share_pkg::*;

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [OP_W*N_REQ-1:0] req_a;
  logic [OP_W*N_REQ-1:0] req_b;
  logic [OP_W-1:0]       mul_a;
  logic [OP_W-1:0]       mul_b;
  logic [PROD_W-1:0]     mul_p;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [PROD_W-1:0]     resp_data;

  modport master (
    output req_valid, req_a, req_b, mul_p, resp_ready,
    input  req_ready, mul_a, mul_b, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_p, resp_ready,
    output req_ready, mul_a, mul_b, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/mult_share_ctrl_rr_pick.sv
// Combinational round-robin search: first valid requester at or after i_rr_ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic [ID_W-1:0]  i_rr_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any_valid
);
  logic            w_found;
  logic [ID_W-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = ID_W'((int'(i_rr_ptr) + k) % N_REQ);
      if (!w_found && i_req_valid[w_j]) begin
        w_found      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
      end
    end
  end

  assign o_any_valid = |i_req_valid;
endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one pipelined 16x16 multiplier among N_REQ requesters, one op in flight.
// Optional completed-op counter on op_count when MULT_SHARE_STATS_EN is defined.
//   state | meaning
//   IDLE  | granting the round-robin winner, operands captured on handshake
//   WAIT  | counting multiplier latency
//   RESP  | product held on the response channel until accepted
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int ID_W     = 2,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_share_ctrl_if.slave     bus,
  output logic                 busy,
  output logic [15:0]          op_count
);
  localparam int CNT_W = $clog2(MULT_LAT + 1);

  state_t              r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [OP_W-1:0]     r_mul_a;
  logic [OP_W-1:0]     r_mul_b;
  logic [PROD_W-1:0]   r_resp_data;
  logic [ID_W-1:0]     r_resp_id;
  logic                r_resp_valid;
  logic [CNT_W-1:0]    r_cnt;

  logic [N_REQ-1:0]    w_grant;
  logic [ID_W-1:0]     w_idx;
  logic                w_any_valid;
  logic                w_done;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr_pick (
    .i_req_valid (bus.req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_idx       (w_idx),
    .o_any_valid (w_any_valid)
  );

  assign w_done = (r_state == RESP) && bus.resp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_resp_data  <= '0;
      r_resp_id    <= '0;
      r_resp_valid <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_mul_a   <= bus.req_a[int'(w_idx)*OP_W +: OP_W];
            r_mul_b   <= bus.req_b[int'(w_idx)*OP_W +: OP_W];
            r_resp_id <= w_idx;
            r_cnt     <= '0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == CNT_W'(MULT_LAT)) begin
            r_resp_data  <= bus.mul_p;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            // Pointer moves past the served requester only once its result is taken.
            r_rr_ptr     <= (r_resp_id == ID_W'(N_REQ - 1)) ? '0 : r_resp_id + ID_W'(1);
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MULT_SHARE_STATS_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_op_count <= '0;
    else if (w_done) r_op_count <= r_op_count + 16'd1;
  end

  assign op_count = r_op_count;
`else
  logic w_unused_done;
  assign w_unused_done = w_done;
  assign op_count      = '0;
`endif

  assign bus.req_ready  = (r_state == IDLE) ? w_grant : '0;
  assign bus.mul_a      = r_mul_a;
  assign bus.mul_b      = r_mul_b;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_data  = r_resp_data;
  assign busy           = (r_state != IDLE);
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: one DUT with 1-cycle multiplier, one with 3-cycle.
module tb_mult_share_ctrl;
  logic clk;
  logic reset;
  logic busy1, busy3;
  logic [15:0] op_count1, op_count3;
  int n_cmp;
  int n_err;

`ifdef MULT_SHARE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  mult_share_ctrl_if #(.N_REQ(4), .ID_W(2)) bus1 ();
  mult_share_ctrl_if #(.N_REQ(4), .ID_W(2)) bus3 ();

  mult_share_ctrl #(.N_REQ(4), .ID_W(2), .MULT_LAT(1)) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus1),
    .busy     (busy1),
    .op_count (op_count1)
  );

  mult_share_ctrl #(.N_REQ(4), .ID_W(2), .MULT_LAT(3)) u_dut3 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus3),
    .busy     (busy3),
    .op_count (op_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] p1;
  logic [31:0] p3_s0, p3_s1, p3_s2;
  always @(posedge clk) begin
    p1    <= bus1.mul_a * bus1.mul_b;
    p3_s0 <= bus3.mul_a * bus3.mul_b;
    p3_s1 <= p3_s0;
    p3_s2 <= p3_s1;
  end
  assign bus1.mul_p = p1;
  assign bus3.mul_p = p3_s2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.resp_ready = 1'b0;
    bus3.req_valid = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", busy1, 0);
    chk("rst_resp_valid", bus1.resp_valid, 0);
    chk("rst_mul_a", bus1.mul_a, 0);
    chk("rst_resp_data", bus1.resp_data, 0);
    chk("rst_op_count", op_count1, 0);

    // single request, 3*5
    tick();
    bus1.req_valid = 4'b0001; bus1.req_a[15:0] = 16'd3; bus1.req_b[15:0] = 16'd5;
    bus1.resp_ready = 1'b1;
    #1;
    chk("t1_req_ready", bus1.req_ready, 4'b0001);
    chk("t1_busy_c0", busy1, 0);
    tick();
    bus1.req_valid = '0;
    #1;
    chk("t1_busy_c1", busy1, 1);
    chk("t1_req_ready_wait", bus1.req_ready, 0);
    chk("t1_mul_a", bus1.mul_a, 3);
    chk("t1_mul_b", bus1.mul_b, 5);
    chk("t1_rv_c1", bus1.resp_valid, 0);
    tick();
    chk("t1_busy_c2", busy1, 1);
    chk("t1_rv_c2", bus1.resp_valid, 0);
    tick();
    chk("t1_rv_c3", bus1.resp_valid, 1);
    chk("t1_id", bus1.resp_id, 0);
    chk("t1_data", bus1.resp_data, 15);
    chk("t1_busy_c3", busy1, 1);
    tick();
    chk("t1_rv_c4", bus1.resp_valid, 0);
    chk("t1_busy_c4", busy1, 0);
    chk("t1_op_count", op_count1, STATS ? 32'd1 : 32'd0);

    // max operands from requester 2
    bus1.req_valid = 4'b0100; bus1.req_a[47:32] = 16'hFFFF; bus1.req_b[47:32] = 16'hFFFF;
    #1;
    chk("t2_req_ready", bus1.req_ready, 4'b0100);
    tick();
    bus1.req_valid = '0;
    tick();
    tick();
    chk("t2_rv", bus1.resp_valid, 1);
    chk("t2_id", bus1.resp_id, 2);
    chk("t2_data", bus1.resp_data, 32'hFFFE0001);
    tick();

    // reset while idle clears pointer and counter
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("r2_op_count", op_count1, 0);
    chk("r2_resp_id", bus1.resp_id, 0);

    // fairness: all valid, a=i+1, b=10
    tick();
    for (int i = 0; i < 4; i++) begin
      bus1.req_a[16*i +: 16] = 16'(i + 1);
      bus1.req_b[16*i +: 16] = 16'd10;
    end
    bus1.req_valid = 4'b1111;
    bus1.resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_grant", bus1.req_ready, 32'(4'b0001 << (k % 4)));
      tick();
      tick();
      tick();
      chk("t3_rv", bus1.resp_valid, 1);
      chk("t3_id", bus1.resp_id, 32'(k % 4));
      chk("t3_data", bus1.resp_data, 32'(10 * ((k % 4) + 1)));
      tick();
    end
    bus1.req_valid = '0;
    #1;
    chk("t3_idle_ready", bus1.req_ready, 0);
    chk("t3_op_count", op_count1, STATS ? 32'd5 : 32'd0);

    // backpressure; rr_ptr=1 so requester 0 is found by wrapping
    tick();
    bus1.req_valid = 4'b0001; bus1.req_a[15:0] = 16'd6; bus1.req_b[15:0] = 16'd7;
    bus1.resp_ready = 1'b0;
    #1;
    chk("t4_grant_wrap", bus1.req_ready, 4'b0001);
    tick();
    bus1.req_valid = 4'b0010;
    #1;
    chk("t4_ready_wait", bus1.req_ready, 0);
    tick();
    tick();
    chk("t4_rv", bus1.resp_valid, 1);
    chk("t4_data", bus1.resp_data, 42);
    for (int s = 0; s < 6; s++) begin
      tick();
      chk("t4_hold_rv", bus1.resp_valid, 1);
      chk("t4_hold_data", bus1.resp_data, 42);
      chk("t4_hold_id", bus1.resp_id, 0);
      chk("t4_hold_ready", bus1.req_ready, 0);
    end
    bus1.resp_ready = 1'b1;
    tick();
    chk("t4_rv_drop", bus1.resp_valid, 0);
    chk("t4_next_grant", bus1.req_ready, 4'b0010);
    tick();
    bus1.req_valid = '0;
    tick();
    tick();
    chk("t4_id2", bus1.resp_id, 1);
    chk("t4_data2", bus1.resp_data, 20);
    tick();

    // reset during WAIT discards the operation
    bus1.req_valid = 4'b1000; bus1.req_a[63:48] = 16'd100; bus1.req_b[63:48] = 16'd3;
    #1;
    chk("t5_grant", bus1.req_ready, 4'b1000);
    tick();
    bus1.req_valid = '0;
    #1;
    chk("t5_busy_wait", busy1, 1);
    reset = 1'b1;
    #1;
    chk("t5_busy_rst", busy1, 0);
    chk("t5_rv_rst", bus1.resp_valid, 0);
    tick();
    tick();
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk("t5_no_resp", bus1.resp_valid, 0);
      chk("t5_idle", busy1, 0);
    end
    chk("t5_op_count", op_count1, 0);
    bus1.req_valid = 4'b1001; bus1.req_a[15:0] = 16'd11; bus1.req_b[15:0] = 16'd13;
    #1;
    chk("t5_grant_ptr0", bus1.req_ready, 4'b0001);
    tick();
    bus1.req_valid = '0;
    tick();
    tick();
    chk("t5_rv", bus1.resp_valid, 1);
    chk("t5_id", bus1.resp_id, 0);
    chk("t5_data", bus1.resp_data, 143);
    tick();

    // MULT_LAT=3 instance, 7*9 from requester 1
    bus3.req_valid = 4'b0010; bus3.req_a[31:16] = 16'd7; bus3.req_b[31:16] = 16'd9;
    bus3.resp_ready = 1'b1;
    #1;
    chk("t6_grant", bus3.req_ready, 4'b0010);
    tick();
    bus3.req_valid = '0;
    bus3.req_a = '0;
    bus3.req_b = '0;
    #1;
    chk("t6_mul_a", bus3.mul_a, 7);
    tick();
    tick();
    chk("t6_mul_b_stable", bus3.mul_b, 9);
    chk("t6_rv_c3", bus3.resp_valid, 0);
    tick();
    chk("t6_rv_c4", bus3.resp_valid, 0);
    tick();
    chk("t6_rv_c5", bus3.resp_valid, 1);
    chk("t6_id", bus3.resp_id, 1);
    chk("t6_data", bus3.resp_data, 63);
    tick();
    chk("t6_busy_after", busy3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
